// File: rtl/systolic_mm_array_if.sv
// Operand-beat and result-row handshake bundle for systolic_mm_array.
// master drives operands and result ready; slave is the array.
interface systolic_mm_array_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned DW    = 32,
   parameter int unsigned K_MAX = 16
);
   localparam int unsigned AW = 2 * DW + $clog2(K_MAX);
   localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;

   logic              in_valid;
   logic              in_ready;
   logic [N*DW-1:0]   a_col;
   logic [N*DW-1:0]   b_row;
   logic              out_valid;
   logic              out_ready;
   logic [RW-1:0]     out_row;
   logic [N*AW-1:0]   out_data;

   modport master (
      output in_valid, a_col, b_row, out_ready,
      input  in_ready, out_valid, out_row, out_data
   );

   modport slave (
      input  in_valid, a_col, b_row, out_ready,
      output in_ready, out_valid, out_row, out_data
   );
endinterface

// File: rtl/systolic_mm_array.sv
// N x N output-stationary systolic multiplier, C = A(NxK) * B(KxN), rows streamed out in order.
// Define SYSTOLIC_SIGNED_EN for two's-complement operands; the default build is unsigned.
module systolic_mm_array #(
   parameter int unsigned N     = 4,
   parameter int unsigned DW    = 32,
   parameter int unsigned K_MAX = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [$clog2(K_MAX):0] k_len_i,
   systolic_mm_array_if.slave     io,
   output logic                   busy_o,
   output logic                   done_o
);
   localparam int unsigned AW = 2 * DW + $clog2(K_MAX);
   localparam int unsigned KW = $clog2(K_MAX) + 1;
   localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = (KW > $clog2(2 * N)) ? KW : $clog2(2 * N);
   localparam int unsigned XW = AW - 2 * DW;

   typedef enum logic [1:0] {StIdle, StLoad, StDrain, StOut} state_e;

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] row_q, row_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          fire, adv, clr;
   logic [DW-1:0] a_src [N];
   logic [DW-1:0] b_src [N];
   logic [DW-1:0] a_pe  [N][N];
   logic [DW-1:0] b_pe  [N][N];
   logic [AW-1:0] acc   [N][N];
   logic [N*AW-1:0] out_data;

   assign fire = (state_q == StLoad) & io.in_valid & in_ready_q;
   assign adv  = fire | (state_q == StDrain);
   assign clr  = (state_q == StIdle) & start_i;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               k_d    = k_len_i;
               cnt_d  = '0;
               row_d  = '0;
               busy_d = 1'b1;
               // Out-of-range K behaves as K=0: straight to an all-zero result.
               if (k_len_i == '0 || k_len_i > KW'(K_MAX)) begin
                  state_d     = StOut;
                  out_valid_d = 1'b1;
               end else begin
                  state_d    = StLoad;
                  in_ready_d = 1'b1;
               end
            end
         end
         StLoad: begin
            if (fire) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q + CW'(1) == CW'(k_q)) begin
                  state_d    = StDrain;
                  in_ready_d = 1'b0;
                  cnt_d      = '0;
               end
            end
         end
         StDrain: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(2 * N - 3)) begin
               state_d     = StOut;
               out_valid_d = 1'b1;
               cnt_d       = '0;
            end
         end
         StOut: begin
            if (io.out_ready) begin
               if (row_q == RW'(N - 1)) begin
                  state_d     = StIdle;
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         k_q         <= '0;
         cnt_q       <= '0;
         row_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Zero operands outside LOAD so the drain phase flushes the pipeline with zeros.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_src[i] = (state_q == StLoad) ? io.a_col[i*DW +: DW] : '0;
         b_src[i] = (state_q == StLoad) ? io.b_row[i*DW +: DW] : '0;
      end
   end

   for (genvar r = 0; r < N; r++) begin : g_skew
      if (r == 0) begin : g_direct
         assign a_pe[0][0] = a_src[0];
         assign b_pe[0][0] = b_src[0];
      end else begin : g_delay
         logic [DW-1:0] ska_q [r];
         logic [DW-1:0] ska_d [r];
         logic [DW-1:0] skb_q [r];
         logic [DW-1:0] skb_d [r];
         always_comb begin
            ska_d = ska_q;
            skb_d = skb_q;
            for (int j = 0; j < r; j++) begin
               if (clr) begin
                  ska_d[j] = '0;
                  skb_d[j] = '0;
               end else if (adv) begin
                  ska_d[j] = (j == 0) ? a_src[r] : ska_q[j-1];
                  skb_d[j] = (j == 0) ? b_src[r] : skb_q[j-1];
               end
            end
         end
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int j = 0; j < r; j++) begin
                  ska_q[j] <= '0;
                  skb_q[j] <= '0;
               end
            end else begin
               ska_q <= ska_d;
               skb_q <= skb_d;
            end
         end
         assign a_pe[r][0] = ska_q[r-1];
         assign b_pe[0][r] = skb_q[r-1];
      end
   end

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         logic [2*DW-1:0] prod;
         logic [AW-1:0]   prod_x;
         logic [AW-1:0]   acc_q, acc_d;
`ifdef SYSTOLIC_SIGNED_EN
         assign prod   = {{DW{a_pe[r][c][DW-1]}}, a_pe[r][c]}
                       * {{DW{b_pe[r][c][DW-1]}}, b_pe[r][c]};
         assign prod_x = {{XW{prod[2*DW-1]}}, prod};
`else
         assign prod   = {{DW{1'b0}}, a_pe[r][c]} * {{DW{1'b0}}, b_pe[r][c]};
         assign prod_x = {{XW{1'b0}}, prod};
`endif
         always_comb begin
            acc_d = acc_q;
            if (clr)      acc_d = '0;
            else if (adv) acc_d = acc_q + prod_x;
         end
         always_ff @(posedge clk_i) begin
            if (rst_i) acc_q <= '0;
            else       acc_q <= acc_d;
         end
         assign acc[r][c] = acc_q;

         if (c < N - 1) begin : g_fwd_a
            logic [DW-1:0] a_q, a_d;
            always_comb begin
               a_d = a_q;
               if (clr)      a_d = '0;
               else if (adv) a_d = a_pe[r][c];
            end
            always_ff @(posedge clk_i) begin
               if (rst_i) a_q <= '0;
               else       a_q <= a_d;
            end
            assign a_pe[r][c+1] = a_q;
         end

         if (r < N - 1) begin : g_fwd_b
            logic [DW-1:0] b_q, b_d;
            always_comb begin
               b_d = b_q;
               if (clr)      b_d = '0;
               else if (adv) b_d = b_pe[r][c];
            end
            always_ff @(posedge clk_i) begin
               if (rst_i) b_q <= '0;
               else       b_q <= b_d;
            end
            assign b_pe[r+1][c] = b_q;
         end
      end
   end

   // Accumulators are frozen in OUT, so the muxed row is stable across stalls.
   always_comb begin
      out_data = '0;
      if (out_valid_q) begin
         for (int c = 0; c < N; c++) out_data[c*AW +: AW] = acc[row_q][c];
      end
   end

   assign io.in_ready  = in_ready_q;
   assign io.out_valid = out_valid_q;
   assign io.out_row   = row_q;
   assign io.out_data  = out_data;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
endmodule
